proc_top: RTL and testbench

- Fixed-function compute engine. After reset release it finds the minimum absolute pairwise distance among 20 signed bytes held in its internal data memory.
- It writes that minimum back to data memory and raises done.
- It contains two addressable storage submodules, data memory instance dm1 and register file instance rf1. The system bench preloads both by hierarchical reference, so their instance and array names are fixed.

---
 rtl/proc_top.sv | 230 +++++++++++++++++++++++
 tb/tb_proc_top.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/proc_top.sv
// rtl/proc_top.sv - minimum absolute pairwise distance engine over N signed bytes in data memory
// Contains the data memory (dm1), register file (rf1) and the sequencing FSM.

module proc_dm #(
    parameter int DW = 8,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata
);
    // Deliberately unreset so that preloaded operands survive a reset pulse.
    logic [DW-1:0] guts [0:(1<<AW)-1];

    assign rdata = guts[raddr];

    always_ff @(posedge clk) begin
        if (we) begin
            guts[waddr] <= wdata;
        end
    end
endmodule

module proc_rf #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we0,
    input  logic [3:0]    wa0,
    input  logic [DW-1:0] wd0,
    input  logic          we1,
    input  logic [3:0]    wa1,
    input  logic [DW-1:0] wd1,
    input  logic [3:0]    ra0,
    output logic [DW-1:0] rd0,
    input  logic [3:0]    ra1,
    output logic [DW-1:0] rd1,
    input  logic [3:0]    ra2,
    output logic [DW-1:0] rd2,
    input  logic [3:0]    ra3,
    output logic [DW-1:0] rd3
);
    logic [DW-1:0] core [0:15];

    assign rd0 = core[ra0];
    assign rd1 = core[ra1];
    assign rd2 = core[ra2];
    assign rd3 = core[ra3];

    // Entry 15 holds the constant one; everything else clears on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 15; i++) begin
                core[i] <= '0;
            end
            core[15] <= DW'(1);
        end else begin
            if (we0) begin
                core[wa0] <= wd0;
            end
            if (we1) begin
                core[wa1] <= wd1;
            end
        end
    end
endmodule

module proc_top #(
    parameter int BASE     = 128,
    parameter int N        = 20,
    parameter int RES_ADDR = 127,
    parameter int DW       = 8
) (
    input  logic clk,
    input  logic reset,
    output logic done
);
    localparam int AW = 8;
    localparam logic [3:0] REG_K   = 4'd0;
    localparam logic [3:0] REG_J   = 4'd1;
    localparam logic [3:0] REG_A   = 4'd2;
    localparam logic [3:0] REG_MIN = 4'd3;
    localparam logic [AW-1:0] BASE_A = AW'(BASE);
    localparam logic [AW-1:0] LAST_K = AW'(BASE + N - 1);
    localparam logic [AW-1:0] RES_A  = AW'(RES_ADDR);

    typedef enum logic [2:0] {
        ST_RST,
        ST_INIT,
        ST_LOADK,
        ST_PAIR,
        ST_STORE,
        ST_DONE
    } state_t;

    state_t state;

    logic [DW-1:0] k_val;
    logic [DW-1:0] j_val;
    logic [DW-1:0] a_val;
    logic [DW-1:0] min_val;
    logic [DW-1:0] mem_rdata;
    logic [AW-1:0] mem_raddr;

    logic          we0;
    logic [3:0]    wa0;
    logic [DW-1:0] wd0;
    logic          we1;
    logic [3:0]    wa1;
    logic [DW-1:0] wd1;

    logic [DW:0]   diff;
    logic [DW:0]   mag;
    logic          j_last;
    logic          k_last;
    logic          better;

    proc_rf #(.DW(DW)) rf1 (
        .clk   (clk),
        .reset (reset),
        .we0   (we0),
        .wa0   (wa0),
        .wd0   (wd0),
        .we1   (we1),
        .wa1   (wa1),
        .wd1   (wd1),
        .ra0   (REG_K),
        .rd0   (k_val),
        .ra1   (REG_J),
        .rd1   (j_val),
        .ra2   (REG_A),
        .rd2   (a_val),
        .ra3   (REG_MIN),
        .rd3   (min_val)
    );

    proc_dm #(.DW(DW), .AW(AW)) dm1 (
        .clk   (clk),
        .raddr (mem_raddr),
        .rdata (mem_rdata),
        .we    (state == ST_STORE),
        .waddr (RES_A),
        .wdata (min_val)
    );

    assign mem_raddr = (state == ST_LOADK) ? AW'(k_val) : AW'(j_val);

    // Sign-extend to DW+1 bits so the full -255..255 difference range is exact.
    assign diff   = {a_val[DW-1], a_val} - {mem_rdata[DW-1], mem_rdata};
    assign mag    = diff[DW] ? (~diff + 1'b1) : diff;
    assign better = (mag < {1'b0, min_val});
    assign j_last = (j_val == (k_val - 1'b1));
    assign k_last = (AW'(k_val) == LAST_K);

    always_comb begin
        we0 = 1'b0;
        wa0 = REG_MIN;
        wd0 = '0;
        we1 = 1'b0;
        wa1 = REG_K;
        wd1 = '0;
        case (state)
            ST_INIT: begin
                we0 = 1'b1;
                wa0 = REG_MIN;
                wd0 = '1;
                we1 = 1'b1;
                wa1 = REG_K;
                wd1 = DW'(BASE_A + 1'b1);
            end
            ST_LOADK: begin
                we0 = 1'b1;
                wa0 = REG_A;
                wd0 = mem_rdata;
                we1 = 1'b1;
                wa1 = REG_J;
                wd1 = DW'(BASE_A);
            end
            ST_PAIR: begin
                we0 = better;
                wa0 = REG_MIN;
                wd0 = mag[DW-1:0];
                if (j_last) begin
                    we1 = !k_last;
                    wa1 = REG_K;
                    wd1 = k_val + 1'b1;
                end else begin
                    we1 = 1'b1;
                    wa1 = REG_J;
                    wd1 = j_val + 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_RST;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_RST:   state <= ST_INIT;
                ST_INIT:  state <= ST_LOADK;
                ST_LOADK: state <= ST_PAIR;
                ST_PAIR: begin
                    if (j_last && k_last) begin
                        state <= ST_STORE;
                    end else if (j_last) begin
                        state <= ST_LOADK;
                    end
                end
                ST_STORE: begin
                    state <= ST_DONE;
                    done  <= 1'b1;
                end
                ST_DONE: begin
                    done <= 1'b1;
                end
                default:  state <= ST_RST;
            endcase
        end
    end
endmodule

// File: tb/tb_proc_top.sv
// tb/tb_proc_top.sv - directed self-checking bench for proc_top
module tb_proc_top;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic reset2 = 1'b0;
    logic done;
    logic done2;
    int checks = 0;
    int errors = 0;
    logic [7:0] vals [20];

    always #5 clk = ~clk;

    proc_top dut (
        .clk   (clk),
        .reset (reset),
        .done  (done)
    );

    proc_top #(.N(2)) dut2 (
        .clk   (clk),
        .reset (reset2),
        .done  (done2)
    );

    task automatic hold_reset;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic load_vals;
        for (int i = 0; i < 20; i++) begin
            dut.dm1.guts[128+i] = vals[i];
        end
    endtask

    task automatic set_arith(input int step, input int start);
        for (int i = 0; i < 20; i++) begin
            vals[i] = 8'(i * step + start);
        end
    endtask

    task automatic run_wait(output int cyc, output logic [7:0] pre);
        @(negedge clk);
        reset = 1'b1;
        cyc = 0;
        pre = dut.dm1.guts[127];
        while (cyc < 400 && done !== 1'b1) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 211) pre = dut.dm1.guts[127];
        end
    endtask

    task automatic run_wait2(output int cyc);
        @(negedge clk);
        reset2 = 1'b1;
        cyc = 0;
        while (cyc < 50 && done2 !== 1'b1) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    function automatic int model_min;
        int m = 255;
        int d;
        for (int k = 1; k < 20; k++) begin
            for (int j = 0; j < k; j++) begin
                d = int'($signed(vals[k])) - int'($signed(vals[j]));
                if (d < 0) d = -d;
                if (d < m) m = d;
            end
        end
        return m;
    endfunction

    task automatic test_reset;
        reset = 1'b0;
        dut.dm1.guts[200] = 8'h5A;
        @(negedge clk);
        dut.rf1.core[5] = 8'h55;
        repeat (3) @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (done2 !== 1'b0) begin errors++; $display("FAIL reset_done2: got %b expected 0", done2); end
        checks++; if (dut.rf1.core[14] !== 8'd0) begin errors++; $display("FAIL reset_core14: got %0d expected 0", dut.rf1.core[14]); end
        checks++; if (dut.rf1.core[15] !== 8'd1) begin errors++; $display("FAIL reset_core15: got %0d expected 1", dut.rf1.core[15]); end
        checks++; if (dut.rf1.core[5] !== 8'd0) begin errors++; $display("FAIL reset_core5: got %0d expected 0", dut.rf1.core[5]); end
        checks++; if (dut.dm1.guts[200] !== 8'h5A) begin errors++; $display("FAIL reset_mem_kept: got %h expected 5a", dut.dm1.guts[200]); end
    endtask

    task automatic test_arith;
        int cyc;
        logic [7:0] pre;
        hold_reset();
        set_arith(13, -128);
        load_vals();
        run_wait(cyc, pre);
        checks++; if (cyc !== 212) begin errors++; $display("FAIL arith_latency: got %0d expected 212", cyc); end
        checks++; if (dut.dm1.guts[127] !== 8'd13) begin errors++; $display("FAIL arith_result: got %0d expected 13", dut.dm1.guts[127]); end
    endtask

    task automatic test_duplicate;
        int cyc;
        logic [7:0] pre;
        hold_reset();
        set_arith(13, -128);
        vals[17] = vals[2];
        load_vals();
        run_wait(cyc, pre);
        checks++; if (cyc !== 212) begin errors++; $display("FAIL dup_latency: got %0d expected 212", cyc); end
        checks++; if (dut.dm1.guts[127] !== 8'd0) begin errors++; $display("FAIL dup_result: got %0d expected 0", dut.dm1.guts[127]); end
    endtask

    task automatic test_boundary_pairs;
        int cyc;
        logic [7:0] pre;
        hold_reset();
        set_arith(13, -128);
        vals[1] = 8'(-127);
        load_vals();
        run_wait(cyc, pre);
        checks++; if (dut.dm1.guts[127] !== 8'd1) begin errors++; $display("FAIL first_pair_result: got %0d expected 1", dut.dm1.guts[127]); end
        hold_reset();
        set_arith(13, -128);
        vals[19] = 8'd5;
        load_vals();
        run_wait(cyc, pre);
        checks++; if (cyc !== 212) begin errors++; $display("FAIL last_k_latency: got %0d expected 212", cyc); end
        checks++; if (dut.dm1.guts[127] !== 8'd3) begin errors++; $display("FAIL last_k_result: got %0d expected 3", dut.dm1.guts[127]); end
    endtask

    task automatic test_random;
        int cyc;
        int exp;
        logic [7:0] pre;
        for (int s = 0; s < 3; s++) begin
            hold_reset();
            for (int i = 0; i < 20; i++) vals[i] = 8'($urandom);
            exp = model_min();
            load_vals();
            run_wait(cyc, pre);
            checks++; if (cyc !== 212) begin errors++; $display("FAIL random%0d_latency: got %0d expected 212", s, cyc); end
            checks++; if (dut.dm1.guts[127] !== 8'(exp)) begin errors++; $display("FAIL random%0d_result: got %0d expected %0d", s, dut.dm1.guts[127], exp); end
        end
    endtask

    task automatic test_extremes;
        int cyc;
        logic [7:0] pairs [6];
        logic [7:0] exps [3];
        pairs = '{8'h80, 8'h7F, 8'h7F, 8'h80, 8'h05, 8'h03};
        exps = '{8'd255, 8'd255, 8'd2};
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            reset2 = 1'b0;
            dut2.dm1.guts[128] = pairs[2*t];
            dut2.dm1.guts[129] = pairs[2*t+1];
            @(negedge clk);
            checks++; if (done2 !== 1'b0) begin errors++; $display("FAIL n2_%0d_done_low: got %b expected 0", t, done2); end
            run_wait2(cyc);
            checks++; if (cyc !== 5) begin errors++; $display("FAIL n2_%0d_latency: got %0d expected 5", t, cyc); end
            checks++; if (dut2.dm1.guts[127] !== exps[t]) begin errors++; $display("FAIL n2_%0d_result: got %0d expected %0d", t, dut2.dm1.guts[127], exps[t]); end
        end
    endtask

    task automatic test_reset_mid;
        int cyc;
        logic [7:0] pre;
        hold_reset();
        set_arith(13, -128);
        load_vals();
        dut.dm1.guts[127] = 8'hAA;
        @(negedge clk);
        reset = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        checks++; if (dut.dm1.guts[127] !== 8'hAA) begin errors++; $display("FAIL mid_no_write: got %h expected aa", dut.dm1.guts[127]); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL mid_done: got %b expected 0", done); end
        checks++; if (dut.rf1.core[0] !== 8'd0) begin errors++; $display("FAIL mid_k_reinit: got %0d expected 0", dut.rf1.core[0]); end
        checks++; if (dut.rf1.core[3] !== 8'd0) begin errors++; $display("FAIL mid_min_reinit: got %0d expected 0", dut.rf1.core[3]); end
        @(negedge clk);
        run_wait(cyc, pre);
        checks++; if (pre !== 8'hAA) begin errors++; $display("FAIL mid_pre_store: got %h expected aa", pre); end
        checks++; if (cyc !== 212) begin errors++; $display("FAIL mid_latency: got %0d expected 212", cyc); end
        checks++; if (dut.dm1.guts[127] !== 8'd13) begin errors++; $display("FAIL mid_result: got %0d expected 13", dut.dm1.guts[127]); end
    endtask

    task automatic test_back_to_back;
        int cyc;
        logic [7:0] pre;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done_held: got %b expected 1", done); end
        set_arith(12, -120);
        load_vals();
        repeat (5) @(negedge clk);
        checks++; if (dut.dm1.guts[127] !== 8'd13) begin errors++; $display("FAIL b2b_no_write_in_done: got %0d expected 13", dut.dm1.guts[127]); end
        reset = 1'b0;
        #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_drop: got %b expected 0", done); end
        checks++; if (dut.rf1.core[14] !== 8'd0) begin errors++; $display("FAIL b2b_core14: got %0d expected 0", dut.rf1.core[14]); end
        checks++; if (dut.rf1.core[15] !== 8'd1) begin errors++; $display("FAIL b2b_core15: got %0d expected 1", dut.rf1.core[15]); end
        run_wait(cyc, pre);
        checks++; if (cyc !== 212) begin errors++; $display("FAIL b2b_latency: got %0d expected 212", cyc); end
        checks++; if (dut.dm1.guts[127] !== 8'd12) begin errors++; $display("FAIL b2b_result: got %0d expected 12", dut.dm1.guts[127]); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done_rise: got %b expected 1", done); end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_duplicate();
        test_boundary_pairs();
        test_random();
        test_extremes();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
